// File: rtl/bus_arb_mux_if.sv
// Source-channel and bus-register signals of bus_arb_mux, grouped as one bundle.
// The lock signal exists only when BUSMUX_LOCK_EN is defined.
interface bus_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int SELW  = $clog2(N)
);
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_ready;
`ifdef BUSMUX_LOCK_EN
  logic               lock;
`endif

  // master: the arbiter/mux itself; slave: sources and bus consumer
  modport master (
`ifdef BUSMUX_LOCK_EN
    input  lock,
`endif
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );

  modport slave (
`ifdef BUSMUX_LOCK_EN
    output lock,
`endif
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/bus_arb_mux.sv
// Round-robin N:1 bus arbiter with a single-entry registered output stage.
// Optional source locking is compiled in with BUSMUX_LOCK_EN.

// Per-source eligibility: o_hi marks eligible sources at or above the pointer.
module bus_arb_mux_lane #(
  parameter int SELW = 5,
  parameter int IDX  = 0
) (
  input  logic            i_valid,
  input  logic            i_en,
  input  logic [SELW-1:0] i_ptr,
  output logic            o_elig,
  output logic            o_hi
);
  assign o_elig = i_valid & i_en;
  assign o_hi   = o_elig & (SELW'(IDX) >= i_ptr);
endmodule

module bus_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int SELW  = $clog2(N)
) (
  input logic          clk,
  input logic          rst,
  bus_arb_mux_if.master bus
);
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_src;
  logic [SELW-1:0]  r_ptr;

  logic [N-1:0]     w_en_mask;
  logic [N-1:0]     w_elig;
  logic [N-1:0]     w_hi;
  logic [N-1:0]     w_pick;
  logic [N-1:0]     w_gnt_oh;
  logic [SELW-1:0]  w_g;
  logic [SELW-1:0]  w_g_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_any;
  logic             w_load;
  logic             w_fire;

`ifdef BUSMUX_LOCK_EN
  logic             r_locked;
  logic [SELW-1:0]  r_lsrc;

  // While locked, only the lock holder may win, even if it is idle.
  always_comb begin
    w_en_mask = '0;
    for (int i = 0; i < N; i++)
      w_en_mask[i] = !r_locked || (r_lsrc == SELW'(i));
  end
`else
  assign w_en_mask = '1;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    bus_arb_mux_lane #(.SELW(SELW), .IDX(gi)) u_lane (
      .i_valid (bus.req_valid[gi]),
      .i_en    (w_en_mask[gi]),
      .i_ptr   (r_ptr),
      .o_elig  (w_elig[gi]),
      .o_hi    (w_hi[gi])
    );
  end

  // Two-pass round robin: lowest eligible index at/after ptr, else lowest overall.
  assign w_pick   = (|w_hi) ? w_hi : w_elig;
  assign w_gnt_oh = w_pick & (-w_pick);
  assign w_any    = |w_elig;

  always_comb begin
    w_g = '0;
    for (int i = 0; i < N; i++)
      if (w_gnt_oh[i]) w_g = SELW'(i);
  end

  // Explicit wrap keeps non-power-of-2 N correct.
  assign w_g_nxt = (w_g == SELW'(N - 1)) ? '0 : w_g + SELW'(1);
  assign w_word  = bus.req_data[w_g*WIDTH +: WIDTH];

  assign w_load        = !r_out_valid || bus.out_ready;
  assign w_fire        = w_load && w_any && !rst;
  assign bus.req_ready = w_fire ? w_gnt_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
`ifdef BUSMUX_LOCK_EN
      r_locked    <= 1'b0;
      r_lsrc      <= '0;
`endif
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_src   <= w_g;
`ifdef BUSMUX_LOCK_EN
        if (bus.lock) begin
          r_locked <= 1'b1;
          r_lsrc   <= w_g;
        end else begin
          r_locked <= 1'b0;
          r_ptr    <= w_g_nxt;
        end
`else
        r_ptr       <= w_g_nxt;
`endif
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux: N=32 and N=5 instances sharing clk/rst.
// Lock scenarios run only when BUSMUX_LOCK_EN is defined.
module tb_bus_arb_mux;
  localparam int W  = 32;
  localparam int N  = 32;
  localparam int N5 = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_arb_mux_if #(.WIDTH(W), .N(N))  bus();
  bus_arb_mux_if #(.WIDTH(W), .N(N5)) bus5();

  bus_arb_mux #(.WIDTH(W), .N(N))  dut  (.clk(clk), .rst(rst), .bus(bus.master));
  bus_arb_mux #(.WIDTH(W), .N(N5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.master));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++)  bus.req_data[i*W +: W]  = 32'hA000_0000 + i;
    for (int i = 0; i < N5; i++) bus5.req_data[i*W +: W] = 32'hB000_0000 + i;
`ifdef BUSMUX_LOCK_EN
    bus.lock  = 1'b0;
    bus5.lock = 1'b0;
`endif
    rst            = 1'b1;
    bus.req_valid  = '1;
    bus.out_ready  = 1'b1;
    bus5.req_valid = '0;
    bus5.out_ready = 1'b1;

    // reset held two cycles with all sources requesting
    tick(); tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data",  bus.out_data,  0);
    chk("rst_src",   bus.out_src,   0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst5_valid", bus5.out_valid, 0);

    rst = 1'b0;
    settle();
    chk("first_grant_ready", bus.req_ready, 32'h1);
    tick();
    chk("first_grant_src",   bus.out_src,   0);
    chk("first_grant_valid", bus.out_valid, 1);
    chk("first_grant_data",  bus.out_data,  32'hA000_0000);

    // round robin between sources 0 and 4, one word per cycle
    bus.req_valid = 32'h0000_0011;
    for (int k = 0; k < 4; k++) begin
      int e;
      e = (k % 2 == 0) ? 4 : 0;
      settle();
      chk("rr_ready", bus.req_ready, 64'd1 << e);
      tick();
      chk("rr_src",   bus.out_src,   e);
      chk("rr_data",  bus.out_data,  32'hA000_0000 + e);
      chk("rr_valid", bus.out_valid, 1);
    end

    // back-pressure: output holds source 0's word, ptr=1
    bus.out_ready = 1'b0;
    settle();
    chk("bp_ready0", bus.req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_data",  bus.out_data,  32'hA000_0000);
      chk("bp_src",   bus.out_src,   0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_ready", bus.req_ready, 0);
    end
    bus.out_ready = 1'b1;
    settle();
    chk("bp_release_ready", bus.req_ready, 32'h10);
    tick();
    chk("bp_release_src",   bus.out_src,   4);
    chk("bp_release_valid", bus.out_valid, 1);

    // idle drain after a single word from source 7
    bus.req_valid = 32'h80;
    settle();
    chk("drain_ready", bus.req_ready, 32'h80);
    tick();
    chk("drain_src",  bus.out_src,  7);
    chk("drain_data", bus.out_data, 32'hA000_0007);
    bus.req_valid = '0;
    settle();
    chk("drain_idle_ready", bus.req_ready, 0);
    tick();
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_hold_src",  bus.out_src,  7);
    chk("drain_hold_data", bus.out_data, 32'hA000_0007);

    // N=5: grant 4, ptr wraps to 0, then 0, then 4
    bus5.req_valid = 5'h10;
    settle();
    chk("n5_ready4", bus5.req_ready, 5'h10);
    tick();
    chk("n5_src4",  bus5.out_src,  4);
    chk("n5_data4", bus5.out_data, 32'hB000_0004);
    bus5.req_valid = 5'h11;
    settle();
    chk("n5_wrap_ready", bus5.req_ready, 5'h01);
    tick();
    chk("n5_wrap_src", bus5.out_src, 0);
    settle();
    chk("n5_next_ready", bus5.req_ready, 5'h10);
    tick();
    chk("n5_next_src", bus5.out_src, 4);
    bus5.req_valid = '0;

    // reset with a word in flight discards it
    bus.req_valid = 32'h200;
    settle();
    tick();
    chk("mid_src",   bus.out_src,   9);
    chk("mid_valid", bus.out_valid, 1);
    rst = 1'b1;
    settle();
    chk("mid_rst_ready", bus.req_ready, 0);
    tick();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data",  bus.out_data,  0);
    chk("mid_rst_src",   bus.out_src,   0);
    rst = 1'b0;
    bus.req_valid = '1;
    settle();
    chk("mid_rst_ptr0", bus.req_ready, 32'h1);
    bus.req_valid = '0;
    tick();

`ifdef BUSMUX_LOCK_EN
    // move ptr to 2 with a plain transfer from source 1
    bus.req_valid = 32'h2;
    settle();
    chk("lk_pre_ready", bus.req_ready, 32'h2);
    tick();
    bus.req_valid = 32'hE;
    bus.lock      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("lk_ready", bus.req_ready, 32'h4);
      tick();
      chk("lk_src", bus.out_src, 2);
    end
    bus.req_valid = 32'hA;
    settle();
    chk("lk_excl_ready", bus.req_ready, 0);
    tick();
    bus.req_valid = 32'hE;
    bus.lock      = 1'b0;
    settle();
    chk("lk_release_ready", bus.req_ready, 32'h4);
    tick();
    chk("lk_release_src", bus.out_src, 2);
    settle();
    chk("lk_after3_ready", bus.req_ready, 32'h8);
    tick();
    chk("lk_after3_src", bus.out_src, 3);
    settle();
    chk("lk_after1_ready", bus.req_ready, 32'h2);
    tick();
    chk("lk_after1_src", bus.out_src, 1);
    bus.req_valid = '0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised, registered successor to the flat 32:1 bus select. It collects N source channels, each with a valid/ready handshake, and grants one per cycle by round-robin arbitration. The winner's word goes into a single-entry output register that drives the shared datapath bus. The block sits between the register-file/special-register outputs and the bus consumers (ALU operand latches, MAR/MDR), replacing the combinational select with stall-aware flow control.

## Interface
Parameters:
- WIDTH, 32, data width of every channel and of the bus
- N, 32, number of source channels (2..64, need not be a power of 2)
- SELW, $clog2(N), width of the source-index field

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high (the only reset in the block)
- req_valid  input  N  bit i set when source i presents a word
- req_data  input  N*WIDTH  source i word at bits [i*WIDTH +: WIDTH]
- req_ready  output  N  combinational; bit i set when source i's word is accepted this cycle
- out_valid  output  1  bus register holds a valid word
- out_data  output  WIDTH  registered bus word
- out_src  output  SELW  index of the source that produced out_data
- out_ready  input  1  consumer accepts the bus word this cycle
- lock  input  1  present only with BUSMUX_LOCK_EN (see Configuration)

## Operation
- Output register `load = !out_valid || out_ready` (single-entry pipeline, full throughput).
- Arbitration pointer `ptr` (SELW bits) sets the highest-priority index. Grant `g` is the first i with req_valid[i] set, scanning ptr, ptr+1, … N-1, 0, … ptr-1.
- `req_ready[i] = load && any(req_valid) && (i == g)`. At most one bit is set. `req_ready` never depends on `req_valid[i]` of the winner beyond the grant scan.
- Transfer from source g (req_valid[g] && req_ready[g]):
  - out_data <= word g
  - out_src <= g
  - out_valid <= 1
  - ptr <= (g == N-1) ? 0 : g+1. Wrap is explicit, so it is correct for non-power-of-2 N.
- `load` with no req_valid bits set: out_valid <= 0. out_data and out_src hold their values. ptr holds.
- !load (out_valid && !out_ready): all registers hold, req_ready = 0.
- Simultaneous drain and refill (out_valid && out_ready && request present): the new word replaces the old word in the same edge, with no bubble.
- Invariant: a granted source is never starved longer than N-1 transfers while it holds req_valid.

## Timing
- Reset (rst high at a clk edge): out_valid=0, out_data=0, out_src=0, ptr=0, lock state cleared. rst overrides every other input in that cycle, and req_ready is 0 while rst is high.
- Reset mid-transfer: an in-flight out word is discarded. No source sees req_ready during the reset cycle.
- Latency: source word accepted on edge k appears on out_data/out_valid after edge k, and is visible in cycle k+1.
- Throughput: 1 word/cycle when out_ready is held high.
- req_ready is combinational from req_valid, ptr, out_valid and out_ready. out_* are purely registered.

## Configuration
- Macro BUSMUX_LOCK_EN.
- Defined:
  - `lock` port exists. A transfer from source g with lock=1 sets locked=1 and lsrc=g, and does not advance ptr.
  - While locked=1, only lsrc may be granted. Other sources get no req_ready even if lsrc is idle.
  - A transfer from lsrc with lock=0 clears locked and advances ptr to lsrc+1 (with wrap).
  - locked and lsrc reset to 0.
- Undefined: no `lock` port, no locked/lsrc state. Pure round-robin as above.

## Test plan
- Reset: hold rst 2 cycles with req_valid=all-ones -> out_valid=0, out_data=0, out_src=0, req_ready=0. First cycle after reset grants source 0.
- Round-robin: N=32, req_valid=0x0000_0011, out_ready=1, data_i=0xA000_0000+i -> out_src sequence 0,4,0,4… and out_data 0xA000_0000, 0xA000_0004, one per cycle.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles with requests pending -> out_data stable, req_ready=0, ptr unchanged. Raising out_ready gives next grant the same cycle, with no bubble.
- Wrap with non-power-of-2: N=5, only source 4 valid, then sources 0 and 4 valid -> grant 4 then 0, and ptr wraps from 4 to 0.
- Idle drain: single transfer from source 7, then req_valid=0 with out_ready=1 -> out_valid drops the next cycle, while out_data and out_src hold 7's word.
- Lock (BUSMUX_LOCK_EN): source 2 sends with lock=1 for 3 words while sources 1 and 3 are valid -> out_src=2,2,2. Fourth word from 2 with lock=0, then sources 3 and 1 are granted in that order.
